// File: rtl/pipe_flopr.sv
// Purpose: DEPTH-stage pipeline register carrying an N-bit payload with per-stage valid bits.
// Latency: DEPTH-1 cycles after the accepting edge when the pipe is empty and unstalled (0 for DEPTH=1).
// Backpressure: stall holds the head. Empty stages collapse, and in_ready is combinational from stall.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid, d       upstream offer and its payload
//   in_ready          d is taken on this edge when in_valid is also high
//   stall             downstream does not consume q this cycle
//   flush             discard all contents on this edge (input offered on the same edge is dropped)
//   q, out_valid      head-of-pipe payload and its valid bit
//   occupancy         number of valid stages
module pipe_flopr #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [N-1:0]               d,
    output logic                       in_ready,
    input  logic                       stall,
    input  logic                       flush,
    output logic [N-1:0]               q,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH+1);

    logic [N-1:0]     data [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;   // stage k hands its entry on this edge
    logic [DEPTH-1:0] room;  // stage k can take a new entry this edge

    // Walk from the head back to stage 0. A stage has room if it is empty,
    // or if its own entry is leaving. The running variable carries the room
    // of the stage ahead, so the vectors are never read inside this block.
    always_comb begin
        logic nxt_room;
        adv      = '0;
        room     = '0;
        nxt_room = ~stall;
        for (int k = DEPTH-1; k >= 0; k--) begin
            adv[k]   = v[k] & nxt_room;
            room[k]  = ~v[k] | adv[k];
            nxt_room = room[k];
        end
    end

    assign in_ready  = room[0];
    assign q         = data[DEPTH-1];
    assign out_valid = v[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OW'(v[k]);
        end
    end

    // A stage captures only when the stage behind it advances (or, for stage 0,
    // when an input is accepted). Otherwise it keeps its entry, or goes empty
    // if that entry moved on. Data is left untouched when a stage empties, so
    // q holds its last value while out_valid is low.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k == 0) begin
                    if (in_valid && room[0]) begin
                        v[0]    <= 1'b1;
                        data[0] <= d;
                    end else if (adv[0]) begin
                        v[0] <= 1'b0;
                    end
                end else begin
                    if (adv[k-1]) begin
                        v[k]    <= 1'b1;
                        data[k] <= data[k-1];
                    end else if (adv[k]) begin
                        v[k] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_flopr.sv
module tb_pipe_flopr;

    localparam int N     = 64;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH+1);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [N-1:0]  d;
    logic          in_ready;
    logic          stall;
    logic          flush;
    logic [N-1:0]  q;
    logic          out_valid;
    logic [OW-1:0] occupancy;

    int checks   = 0;
    int failures = 0;

    pipe_flopr #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .d         (d),
        .in_ready  (in_ready),
        .stall     (stall),
        .flush     (flush),
        .q         (q),
        .out_valid (out_valid),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and let registered outputs settle.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b1; d = 64'hDEADBEEF; stall = 1'b0; flush = 1'b0;
        tick; tick;
        checks++; if (q !== '0) begin failures++; $display("FAIL reset_q got=%h exp=0", q); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (occupancy !== 0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        reset = 1'b0; in_valid = 1'b0;
        tick;
        checks++; if (occupancy !== 0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_nocap occ=%0d ov=%b exp occ=0 ov=0", occupancy, out_valid); end
    endtask

    task automatic test_stream;
        stall = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; d = 64'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready); end
            tick;
            if (i >= 4) begin
                checks++;
                if (out_valid !== 1'b1 || q !== 64'(i-3) || occupancy !== 4) begin
                    failures++; $display("FAIL stream_out i=%0d got ov=%b q=%0d occ=%0d exp ov=1 q=%0d occ=4", i, out_valid, q, occupancy, i-3);
                end
            end else begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_early i=%0d got ov=%b exp=0", i, out_valid); end
            end
        end
        in_valid = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick;
            checks++;
            if (out_valid !== 1'b1 || q !== 64'(5+j) || occupancy !== OW'(4-j)) begin
                failures++; $display("FAIL stream_drain j=%0d got ov=%b q=%0d occ=%0d exp ov=1 q=%0d occ=%0d", j, out_valid, q, occupancy, 5+j, 4-j);
            end
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || q !== 64'd8 || occupancy !== 0) begin
            failures++; $display("FAIL stream_empty got ov=%b q=%0d occ=%0d exp ov=0 q=8 occ=0", out_valid, q, occupancy);
        end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; d = 64'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_fill_rdy i=%0d got=%b exp=1", i, in_ready); end
            tick;
        end
        in_valid = 1'b1; d = 64'd5;
        #1;
        checks++;
        if (in_ready !== 1'b0 || occupancy !== 4 || q !== 64'd1 || out_valid !== 1'b1) begin
            failures++; $display("FAIL stall_full got rdy=%b occ=%0d q=%0d ov=%b exp rdy=0 occ=4 q=1 ov=1", in_ready, occupancy, q, out_valid);
        end
        tick; tick;
        checks++;
        if (in_ready !== 1'b0 || occupancy !== 4 || q !== 64'd1) begin
            failures++; $display("FAIL stall_hold got rdy=%b occ=%0d q=%0d exp rdy=0 occ=4 q=1", in_ready, occupancy, q);
        end
        stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                in_valid = 1'b1; d = 64'd5;
                #1;
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_rdy got=%b exp=1", in_ready); end
            end else if (k == 1) begin
                in_valid = 1'b1; d = 64'd6;
            end else begin
                in_valid = 1'b0;
            end
            tick;
            checks++;
            if (out_valid !== 1'b1 || q !== 64'(k+2) || occupancy !== OW'((k < 2) ? 4 : 5-k)) begin
                failures++; $display("FAIL stall_drain k=%0d got ov=%b q=%0d occ=%0d exp ov=1 q=%0d occ=%0d", k, out_valid, q, occupancy, k+2, (k < 2) ? 4 : 5-k);
            end
        end
        tick;
        checks++; if (out_valid !== 1'b0 || occupancy !== 0) begin failures++; $display("FAIL stall_empty got ov=%b occ=%0d exp ov=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_bubble;
        stall = 1'b1;
        in_valid = 1'b1; d = 64'hA;
        tick;
        in_valid = 1'b0;
        tick; tick;
        in_valid = 1'b1; d = 64'hB;
        tick;
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2 || q !== 64'hA || out_valid !== 1'b1) begin
            failures++; $display("FAIL bubble_gap got occ=%0d q=%h ov=%b exp occ=2 q=a ov=1", occupancy, q, out_valid);
        end
        tick; tick;
        checks++;
        if (occupancy !== 2 || q !== 64'hA) begin
            failures++; $display("FAIL bubble_collapse got occ=%0d q=%h exp occ=2 q=a", occupancy, q);
        end
        stall = 1'b0;
        tick;
        checks++;
        if (q !== 64'hB || out_valid !== 1'b1 || occupancy !== 1) begin
            failures++; $display("FAIL bubble_next got q=%h ov=%b occ=%0d exp q=b ov=1 occ=1", q, out_valid, occupancy);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 0 || q !== 64'hB) begin
            failures++; $display("FAIL bubble_empty got ov=%b occ=%0d q=%h exp ov=0 occ=0 q=b", out_valid, occupancy, q);
        end
    endtask

    task automatic test_flush;
        stall = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; d = 64'(i * 17);
            tick;
        end
        in_valid = 1'b0;
        checks++; if (occupancy !== 3 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_pre got occ=%0d ov=%b exp occ=3 ov=0", occupancy, out_valid); end
        in_valid = 1'b1; d = 64'h55; flush = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (occupancy !== 0 || out_valid !== 1'b0 || q !== '0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_clear got occ=%0d ov=%b q=%h rdy=%b exp occ=0 ov=0 q=0 rdy=1", occupancy, out_valid, q, in_ready);
        end
        for (int j = 0; j < 5; j++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0 || q !== '0) begin
                failures++; $display("FAIL flush_dropped j=%0d got ov=%b q=%h exp ov=0 q=0", j, out_valid, q);
            end
        end
    endtask

    task automatic test_full_release;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; d = 64'(8'h71 + i);
            tick;
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || occupancy !== 4 || q !== 64'h71) begin
            failures++; $display("FAIL fullrel_full got rdy=%b occ=%0d q=%h exp rdy=0 occ=4 q=71", in_ready, occupancy, q);
        end
        stall = 1'b0; in_valid = 1'b1; d = 64'h77;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fullrel_rdy got=%b exp=1", in_ready); end
        tick;
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 4 || q !== 64'h72 || out_valid !== 1'b1) begin
            failures++; $display("FAIL fullrel_swap got occ=%0d q=%h ov=%b exp occ=4 q=72 ov=1", occupancy, q, out_valid);
        end
        for (int j = 0; j < 3; j++) begin
            tick;
            checks++;
            if (q !== ((j == 2) ? 64'h77 : 64'(8'h73 + j)) || occupancy !== OW'(3-j) || out_valid !== 1'b1) begin
                failures++; $display("FAIL fullrel_drain j=%0d got q=%h occ=%0d ov=%b exp occ=%0d ov=1", j, q, occupancy, out_valid, 3-j);
            end
        end
        tick;
        checks++; if (out_valid !== 1'b0 || occupancy !== 0) begin failures++; $display("FAIL fullrel_empty got ov=%b occ=%0d exp ov=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_midstream_reset;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; d = 64'(8'h81 + i);
            tick;
        end
        in_valid = 1'b1; d = 64'h99; reset = 1'b1;
        tick;
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if (occupancy !== 0 || q !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset got occ=%0d q=%h ov=%b rdy=%b exp occ=0 q=0 ov=0 rdy=1", occupancy, q, out_valid, in_ready);
        end
        stall = 1'b0;
        tick;
        checks++; if (occupancy !== 0) begin failures++; $display("FAIL midreset_nocap got occ=%0d exp=0", occupancy); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; d = '0; stall = 1'b0; flush = 1'b0;
        test_reset;
        test_stream;
        test_stall;
        test_bubble;
        test_flush;
        test_full_release;
        test_midstream_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_flopr.md
# pipe_flopr

Parametrised multi-stage pipeline register: the successor of the single-stage reset flip-flop, used between stages of the pipelined LEGv8 datapath. It carries an N-bit payload through DEPTH register stages with a valid bit per stage, a downstream stall, a synchronous flush, and bubble collapsing so that empty stages never block upstream data. It sits between two pipeline stages and exposes a valid/ready handshake on both sides.

## Interface
- N, 64, payload width in bits (N >= 1)
- DEPTH, 4, number of register stages (DEPTH >= 1)
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream offers d this cycle
- d  input  N  upstream payload
- in_ready  output  1  pipeline accepts d on this edge
- stall  input  1  downstream does not consume q this cycle
- flush  input  1  discard all contents on this edge
- q  output  N  payload of last stage (stage DEPTH-1)
- out_valid  output  1  valid bit of last stage
- occupancy  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- State: per stage k (0..DEPTH-1) a data register data[k] and a valid bit v[k]. Stage 0 is the input side.
- Priority per edge: reset > flush > normal advance.
- Reset: all v[k] <= 0, all data[k] <= 0. Outputs after reset: q=0, out_valid=0, occupancy=0, in_ready=1.
- Flush: all v[k] <= 0, all data[k] <= 0; any input offered on the same edge is dropped, and the output is not counted as consumed.
- Advance rule (combinational): adv[DEPTH-1] = v[DEPTH-1] & ~stall; for k < DEPTH-1, adv[k] = v[k] & (~v[k+1] | adv[k+1]).
- Stage k+1 captures data[k] when v[k] & (~v[k+1] | adv[k+1]); stage 0 captures d when in_valid & in_ready.
- A stage that neither captures nor keeps its entry clears v[k]; its data register holds its old value. Data registers load only when capturing a valid entry.
- in_ready = ~v[0] | adv[0]. This is combinational from stall through the chain, with no register break.
- Handshakes: input transfer = in_valid & in_ready at the edge; output transfer = out_valid & ~stall at the edge.
- occupancy = popcount(v), a combinational function of registered state.
- Ordering is preserved. No entry is duplicated or lost except by flush or reset.

## Timing
- Latency: with an empty pipe and stall=0, a value accepted on edge t is presented on q with out_valid=1 after edge t+DEPTH-1. For DEPTH=1 it is presented immediately after the accepting edge.
- Throughput: one transfer per cycle when stall=0. When full, accept and drain can occur on the same edge.
- Full with stall=1: in_ready=0, and all contents and q hold.
- Full with stall dropping to 0: in_ready=1 in the same cycle, and the new input is accepted on that edge.
- Bubbles collapse: while stall=1, entries advance until they reach the first occupied stage.
- in_valid=0: nothing is captured at stage 0, and v[0] clears if its entry advances.
- Reset or flush asserted mid-stream takes effect on that edge regardless of stall. Stream resumes next cycle with in_ready=1.
- q is stable between edges. It holds its value while out_valid=0, except that reset or flush forces it to 0.

## Test plan
1. Reset with in_valid=1, d=0xDEADBEEF held for 2 cycles -> q=0, out_valid=0, occupancy=0, in_ready=1; nothing is captured.
2. Stream 1..8 on consecutive cycles, stall=0, DEPTH=4 -> value 1 appears after edge 4 (counting the accept edge as 1), then 2..8 on consecutive cycles; occupancy steady at 4.
3. stall=1 while offering 1..6 -> 1..4 accepted, in_ready=0 after the 4th accept, occupancy=4, q=1 held. Release stall -> 1,2,3,4 leave one per cycle, then 5,6, with no loss or duplication.
4. stall=1; offer 0xA, idle 2 cycles, offer 0xB -> occupancy=2 with 0xB in stage 2. Release stall -> 0xA then 0xB on consecutive cycles.
5. Pipe holding 3 entries; flush=1 with in_valid=1, d=0x55 -> next cycle occupancy=0, out_valid=0, q=0; 0x55 never appears at q.
6. Pipe full with stall=1; drop stall with in_valid=1, d=0x77 in the same cycle -> in_ready=1 that cycle, 0x77 accepted, head drained, occupancy stays 4.
